// File: rtl/fetch_pkg.sv
// Shared fetch-side types: history and checkpoint widths, checkpoint
// index/count types and the GHR controller FSM encoding.
package fetch_pkg;

  localparam int GHR_W_DEF      = 8;
  localparam int CKPT_DEPTH_DEF = 8;
  localparam int CKPT_IDX_W_DEF = $clog2(CKPT_DEPTH_DEF);

  typedef logic [GHR_W_DEF-1:0]      ghr_t;
  typedef logic [CKPT_IDX_W_DEF-1:0] ckpt_idx_t;
  typedef logic [CKPT_IDX_W_DEF:0]   ckpt_cnt_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ghr_fsm_t;

endpackage

// File: rtl/fetch_ghr_ckpt_ram.sv
// Checkpoint register file: one synchronous write port, one asynchronous
// read port. Holds the pre-update GHR for each in-flight branch.
module fetch_ghr_ckpt_ram
  import fetch_pkg::*;
#(
  parameter int GHR_W      = GHR_W_DEF,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
  parameter int CKPT_IDX_W = $clog2(CKPT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [CKPT_IDX_W-1:0] waddr,
  input  logic [GHR_W-1:0]      wdata,
  input  logic [CKPT_IDX_W-1:0] raddr,
  output logic [GHR_W-1:0]      rdata
);

  logic [GHR_W-1:0] mem [CKPT_DEPTH];

  // NOTE: contents are not reset; a slot is always written before any
  // redirect can read it, so a reset would only cost flops and fanout.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ghr_ctrl.sv
// Speculative fetch GHR controller: shifts predictions into fetch_ghr,
// checkpoints history per branch and restores it on redirect.
// Optional redirect counter enabled by `define FETCH_GHR_CTRL_PERF_EN.
module fetch_ghr_ctrl
  import fetch_pkg::*;
#(
  parameter int GHR_W      = GHR_W_DEF,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEF,
  parameter int CKPT_IDX_W = $clog2(CKPT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pred_valid,
  input  logic                  pred_taken,
  output logic                  pred_ready,
  output logic [CKPT_IDX_W-1:0] pred_tag,
  input  logic                  cmt_valid,
  input  logic                  redir_valid,
  input  logic [CKPT_IDX_W-1:0] redir_tag,
  input  logic                  redir_taken,
  output logic                  ghr_wen,
  output logic [GHR_W-1:0]      ghr_wdata,
  input  logic [GHR_W-1:0]      ghr_rdata,
  output logic [CKPT_IDX_W:0]   ckpt_cnt
`ifdef FETCH_GHR_CTRL_PERF_EN
  ,
  output logic [15:0]           perf_redir_cnt
`endif
);

  localparam logic [CKPT_IDX_W-1:0] IDX_ONE   = 1;
  localparam logic [CKPT_IDX_W:0]   DEPTH_CNT = (CKPT_IDX_W+1)'(CKPT_DEPTH);

  ghr_fsm_t                state, state_nxt;
  logic [CKPT_IDX_W-1:0]   wptr, wptr_nxt, rptr, rptr_nxt;
  logic [CKPT_IDX_W:0]     cnt_nxt;
  logic [CKPT_IDX_W-1:0]   redir_off;
  logic [GHR_W-1:0]        ckpt_rdata;
  logic                    accept, commit, redir_hit, full;

  fetch_ghr_ckpt_ram #(
    .GHR_W     (GHR_W),
    .CKPT_DEPTH(CKPT_DEPTH),
    .CKPT_IDX_W(CKPT_IDX_W)
  ) u_ckpt_ram (
    .clk  (clk),
    .we   (accept),
    .waddr(wptr),
    .wdata(ghr_rdata),
    .raddr(redir_tag),
    .rdata(ckpt_rdata)
  );

  // Age of the redirected slot relative to the oldest in-flight branch.
  assign redir_off  = redir_tag - rptr;
  assign redir_hit  = resetn & redir_valid & ({1'b0, redir_off} < ckpt_cnt);
  assign full       = (ckpt_cnt == DEPTH_CNT);
  assign pred_ready = resetn & (state == RUN) & ~redir_valid & ~full;
  assign pred_tag   = wptr;
  assign accept     = pred_valid & pred_ready;
  assign commit     = resetn & cmt_valid & (ckpt_cnt != '0);

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ghr_wen   = 1'b0;
    ghr_wdata = '0;
    state_nxt = RUN;
    wptr_nxt  = wptr;
    rptr_nxt  = commit ? rptr + IDX_ONE : rptr;
    cnt_nxt   = ckpt_cnt + {{CKPT_IDX_W{1'b0}}, accept}
                         - {{CKPT_IDX_W{1'b0}}, commit};
    if (redir_hit) begin
      // The mispredicted branch stays in flight; everything younger is dropped.
      ghr_wen   = 1'b1;
      ghr_wdata = {ckpt_rdata[GHR_W-2:0], redir_taken};
      state_nxt = RECOVER;
      wptr_nxt  = redir_tag + IDX_ONE;
      cnt_nxt   = {1'b0, redir_off} + {{CKPT_IDX_W{1'b0}}, 1'b1}
                                    - {{CKPT_IDX_W{1'b0}}, commit};
    end else if (accept) begin
      ghr_wen   = 1'b1;
      ghr_wdata = {ghr_rdata[GHR_W-2:0], pred_taken};
      wptr_nxt  = wptr + IDX_ONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= RUN;
      wptr     <= '0;
      rptr     <= '0;
      ckpt_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      ckpt_cnt <= cnt_nxt;
    end
  end

`ifdef FETCH_GHR_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      perf_redir_cnt <= '0;
    else if (redir_hit && perf_redir_cnt != 16'hFFFF)
      perf_redir_cnt <= perf_redir_cnt + 16'd1;
  end
`endif

endmodule
